// File: rtl/display_rx.sv
// Parallel RGB565 display receiver: recovers pixel coordinates, measures frame
// geometry (active size and totals) and reports when that geometry is stable.
module display_rx #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  input  logic [15:0]      color,
  output logic             pix_valid,
  output logic [15:0]      pix_color,
  output logic [9:0]       x,
  output logic [9:0]       y,
  output logic             frame_start,
  output logic             line_start,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] height,
  output logic [CNT_W-1:0] htotal,
  output logic [CNT_W-1:0] vtotal,
  output logic             meas_valid,
  output logic             locked,
  output logic             line_err
);

  localparam int unsigned MATCH_W = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // input stage and previous-value flops
  logic        s_hs, s_vs, s_de;
  logic [15:0] s_col;
  logic        p_hs, p_vs, p_de;

  logic [CNT_W-1:0]   hcnt, line_len, acnt, frame_w, vcnt, lcnt;
  logic               first_line, sat_flag, opened;
  logic [MATCH_W-1:0] match_cnt;

  logic               vs_fall, hs_fall, de_rise, de_fall;
  logic [CNT_W-1:0]   line_len_nx, vcnt_nx, lcnt_nx, frame_w_nx;
  logic               sat_now, geom_eq, line_err_nx;
  logic [MATCH_W-1:0] match_nx;

  always_comb begin
    vs_fall     = p_vs & ~s_vs;
    hs_fall     = p_hs & ~s_hs;
    de_rise     = ~p_de & s_de;
    de_fall     = p_de & ~s_de;
    line_len_nx = hs_fall ? sat_inc(hcnt) : line_len;
    vcnt_nx     = hs_fall ? sat_inc(vcnt) : vcnt;
    lcnt_nx     = de_fall ? sat_inc(lcnt) : lcnt;
    frame_w_nx  = (de_fall && first_line) ? acnt : frame_w;
    line_err_nx = de_fall & ~first_line & (acnt != frame_w);
    sat_now     = (hcnt == CNT_MAX) | (acnt == CNT_MAX) |
                  (vcnt == CNT_MAX) | (lcnt == CNT_MAX);
    geom_eq     = ({frame_w_nx, lcnt_nx, line_len_nx, vcnt_nx} ==
                   {width, height, htotal, vtotal});
    // a frame that hit saturation never counts as a match
    match_nx    = '0;
    if (meas_valid && geom_eq && !(sat_flag || sat_now))
      match_nx = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MATCH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_hs        <= 1'b1;
      s_vs        <= 1'b1;
      s_de        <= 1'b0;
      s_col       <= '0;
      p_hs        <= 1'b1;
      p_vs        <= 1'b1;
      p_de        <= 1'b0;
      pix_valid   <= 1'b0;
      pix_color   <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      line_err    <= 1'b0;
      hcnt        <= '0;
      line_len    <= '0;
      acnt        <= '0;
      frame_w     <= '0;
      vcnt        <= '0;
      lcnt        <= '0;
      first_line  <= 1'b1;
      sat_flag    <= 1'b0;
      opened      <= 1'b0;
      match_cnt   <= '0;
      width       <= '0;
      height      <= '0;
      htotal      <= '0;
      vtotal      <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
    end else begin
      s_hs  <= hsync;
      s_vs  <= vsync;
      s_de  <= de;
      s_col <= color;
      p_hs  <= s_hs;
      p_vs  <= s_vs;
      p_de  <= s_de;

      pix_valid   <= s_de;
      pix_color   <= s_col;
      frame_start <= vs_fall;
      line_start  <= hs_fall;
      line_err    <= line_err_nx;

      if (de_rise)     x <= '0;
      else if (s_de)   x <= x + 10'd1;
      if (vs_fall)     y <= '0;
      else if (de_fall) y <= y + 10'd1;

      hcnt     <= hs_fall ? '0 : sat_inc(hcnt);
      line_len <= line_len_nx;
      if (de_rise)     acnt <= CNT_W'(1);
      else if (s_de)   acnt <= sat_inc(acnt);
      frame_w  <= frame_w_nx;

      if (vs_fall)      first_line <= 1'b1;
      else if (de_fall) first_line <= 1'b0;

      vcnt     <= vs_fall ? '0 : vcnt_nx;
      lcnt     <= vs_fall ? '0 : lcnt_nx;
      sat_flag <= vs_fall ? 1'b0 : (sat_flag | sat_now);

      // the first frame boundary after reset only opens a measurement
      if (vs_fall) begin
        opened <= 1'b1;
        if (opened) begin
          width      <= frame_w_nx;
          height     <= lcnt_nx;
          htotal     <= line_len_nx;
          vtotal     <= vcnt_nx;
          meas_valid <= 1'b1;
          match_cnt  <= match_nx;
          locked     <= (match_nx == MATCH_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_display_rx.sv
// Directed bench for display_rx: a small-geometry frame generator driven from a
// table of per-frame steps, plus pixel, reset and sync-loss sequences.
module tb_display_rx;

  localparam int unsigned CNT_W = 12;
  localparam int HA  = 16;
  localparam int HSW = 2;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VSW = 1;
  localparam int VBP = 2;
  localparam int VT  = VA + VFP + VSW + VBP + 1;

  logic             clk = 1'b0;
  logic             reset, hsync, vsync, de;
  logic [15:0]      color;
  logic             pix_valid;
  logic [15:0]      pix_color;
  logic [9:0]       x, y;
  logic             frame_start, line_start;
  logic [CNT_W-1:0] width, height, htotal, vtotal;
  logic             meas_valid, locked, line_err;

  display_rx #(.CNT_W(CNT_W), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .de(de), .color(color),
    .pix_valid(pix_valid), .pix_color(pix_color), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start),
    .width(width), .height(height), .htotal(htotal), .vtotal(vtotal),
    .meas_valid(meas_valid), .locked(locked), .line_err(line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hfp;
    int short_ly;
    int stall;
    int rst_row;
    bit chk_pix;
    bit exp_meas;
    bit exp_lock;
    int exp_w;
    int exp_h;
    int exp_ht;
    int exp_vt;
    int exp_le;
  } step_t;

  step_t steps[19];

  int n_vec = 0;
  int n_err = 0;
  int fs_cnt, ls_cnt, le_cnt;
  bit chk_pix = 1'b0;
  bit rst_chk = 1'b0;
  logic snap_meas, snap_lock;
  logic [CNT_W-1:0] snap_w, snap_h, snap_ht, snap_vt;
  logic        hd[2];
  logic [15:0] hc[2];
  int          hx[2], hy[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
    check({tag, "_pix_color"}, 64'(pix_color), 64'd0);
    check({tag, "_x"}, 64'(x), 64'd0);
    check({tag, "_y"}, 64'(y), 64'd0);
    check({tag, "_pulses"}, 64'({frame_start, line_start, line_err}), 64'd0);
    check({tag, "_width"}, 64'(width), 64'd0);
    check({tag, "_height"}, 64'(height), 64'd0);
    check({tag, "_htotal"}, 64'(htotal), 64'd0);
    check({tag, "_vtotal"}, 64'(vtotal), 64'd0);
    check({tag, "_status"}, 64'({meas_valid, locked}), 64'd0);
  endtask

  // one clock: sample outputs on the falling edge, then drive the next inputs
  task automatic cyc(input logic hs, input logic vs, input logic d, input logic [15:0] col,
                     input int px, input int py, input logic rst);
    @(negedge clk);
    if (frame_start) begin
      fs_cnt++;
      snap_meas = meas_valid;
      snap_lock = locked;
      snap_w    = width;
      snap_h    = height;
      snap_ht   = htotal;
      snap_vt   = vtotal;
    end
    if (line_start) ls_cnt++;
    if (line_err) le_cnt++;
    if (rst_chk) begin
      check_zero("mid_rst");
      rst_chk = 1'b0;
    end
    if (chk_pix) begin
      check("pix_valid", 64'(pix_valid), 64'(hd[1]));
      if (hd[1]) begin
        check("pix_x", 64'(x), 64'(10'(hx[1])));
        check("pix_y", 64'(y), 64'(10'(hy[1])));
        check("pix_color", 64'(pix_color), 64'(hc[1]));
      end
    end
    hd[1] = hd[0]; hc[1] = hc[0]; hx[1] = hx[0]; hy[1] = hy[0];
    hd[0] = d;     hc[0] = col;   hx[0] = px;    hy[0] = py;
    hsync = hs; vsync = vs; de = d; color = col; reset = rst;
    rst_chk = rst;
  endtask

  task automatic run_frame(input step_t s);
    int ht, ly, px, dlen;
    logic d;
    fs_cnt = 0; ls_cnt = 0; le_cnt = 0;
    chk_pix = s.chk_pix;
    ht = HA + s.hfp + HSW + HBP + 1;
    for (int r = 0; r < VT; r++) begin
      for (int c = 0; c < ht; c++) begin
        ly   = r - (VSW + VBP + 1);
        px   = c - (HSW + HBP + 1);
        dlen = (ly == s.short_ly) ? 10 : HA;
        d    = (ly >= 0 && ly < VA && px >= 0 && px < dlen);
        cyc(c >= HSW, r >= VSW, d, 16'(r * 97 + c * 13) ^ 16'h5A3C, px, ly,
            (r == s.rst_row && c == 0));
      end
    end
    for (int k = 0; k < s.stall; k++) cyc(1'b1, 1'b1, 1'b0, 16'h0, 0, 0, 1'b0);
    chk_pix = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; de = 1'b0; color = '0;
    hd[0] = 1'b0; hd[1] = 1'b0; hc[0] = '0; hc[1] = '0;
    hx[0] = 0; hx[1] = 0; hy[0] = 0; hy[1] = 0;

    //          hfp short stall rst  pix   meas  lock  w   h  ht    vt  le
    steps[0]  = '{3,  -1, 0,    -1, 1'b0, 1'b0, 1'b0, 0,  0, 0,    0,  0};
    steps[1]  = '{3,  -1, 0,    -1, 1'b0, 1'b1, 1'b0, 16, 6, 25,   12, 0};
    steps[2]  = '{3,  -1, 0,    -1, 1'b0, 1'b1, 1'b0, 16, 6, 25,   12, 0};
    steps[3]  = '{3,  -1, 0,    -1, 1'b1, 1'b1, 1'b1, 16, 6, 25,   12, 0};
    steps[4]  = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b1, 16, 6, 25,   12, 0};
    steps[5]  = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b0, 16, 6, 33,   12, 0};
    steps[6]  = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b0, 16, 6, 33,   12, 0};
    steps[7]  = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b1, 16, 6, 33,   12, 0};
    steps[8]  = '{11, 3,  0,    -1, 1'b0, 1'b1, 1'b1, 16, 6, 33,   12, 1};
    steps[9]  = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b1, 16, 6, 33,   12, 0};
    steps[10] = '{11, -1, 4200, -1, 1'b0, 1'b1, 1'b1, 16, 6, 33,   12, 0};
    steps[11] = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b0, 16, 6, 4095, 12, 0};
    steps[12] = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b0, 16, 6, 33,   12, 0};
    steps[13] = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b0, 16, 6, 33,   12, 0};
    steps[14] = '{11, -1, 0,    5,  1'b0, 1'b1, 1'b1, 16, 6, 33,   12, 0};
    steps[15] = '{11, -1, 0,    -1, 1'b0, 1'b0, 1'b0, 0,  0, 0,    0,  0};
    steps[16] = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b0, 16, 6, 33,   12, 0};
    steps[17] = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b0, 16, 6, 33,   12, 0};
    steps[18] = '{11, -1, 0,    -1, 1'b0, 1'b1, 1'b1, 16, 6, 33,   12, 0};

    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 16'h0, 0, 0, 1'b1);
    check_zero("rst");
    rst_chk = 1'b0;
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b0, 16'h0, 0, 0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      run_frame(steps[i]);
      check($sformatf("s%0d_frame_start", i), 64'(fs_cnt), 64'd1);
      check($sformatf("s%0d_line_start", i), 64'(ls_cnt), 64'(VT));
      check($sformatf("s%0d_line_err", i), 64'(le_cnt), 64'(steps[i].exp_le));
      check($sformatf("s%0d_meas_valid", i), 64'(snap_meas), 64'(steps[i].exp_meas));
      check($sformatf("s%0d_locked", i), 64'(snap_lock), 64'(steps[i].exp_lock));
      check($sformatf("s%0d_width", i), 64'(snap_w), 64'(steps[i].exp_w));
      check($sformatf("s%0d_height", i), 64'(snap_h), 64'(steps[i].exp_h));
      check($sformatf("s%0d_htotal", i), 64'(snap_ht), 64'(steps[i].exp_ht));
      check($sformatf("s%0d_vtotal", i), 64'(snap_vt), 64'(steps[i].exp_vt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_rx.md
# display_rx

Receiver for the parallel RGB565 display interface driven by the panel timing generator: HSYNC/VSYNC (active low), DE and 16-bit color. It runs on the pixel clock and recovers per-pixel coordinates. It measures the frame geometry and asserts `locked` once the geometry is stable. It sits between a video input pin pair (or the generator, in loopback) and the frame-buffer writer.

## Interface
- `CNT_W`, default 12: width of the internal timing counters. Measured values saturate at 2^CNT_W-1.
- `LOCK_FRAMES`, default 2: number of consecutive matching frame measurements required to assert `locked`.
- `clk`  in  1  pixel clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hsync`  in  1  horizontal sync, active low.
- `vsync`  in  1  vertical sync, active low.
- `de`  in  1  data enable, active high.
- `color`  in  16  RGB565 pixel data, valid while `de`=1.
- `pix_valid`  out  1  registered copy of `de`.
- `pix_color`  out  16  registered pixel data.
- `x`  out  10  active-pixel index within the current line.
- `y`  out  10  active-line index within the current frame.
- `frame_start`  out  1  one-cycle pulse on each VSYNC falling edge.
- `line_start`  out  1  one-cycle pulse on each HSYNC falling edge.
- `width`, `height`  out  CNT_W  active pixels per line and active lines per frame, as measured.
- `htotal`, `vtotal`  out  CNT_W  clocks per line and lines per frame, as measured.
- `meas_valid`  out  1  set when the first complete frame has been measured.
- `locked`  out  1  geometry stable for LOCK_FRAMES comparisons.
- `line_err`  out  1  one-cycle pulse when an active line's width differs from the previous active line of the same frame.

## Operation
- **Stage 1** registers `hsync`, `vsync`, `de`, `color`. Previous-value flops also exist for `hsync`, `vsync`, `de`.
- **Edge definitions**:
  - VSYNC fall = previous 1, current 0.
  - HSYNC fall = previous 1, current 0.
  - DE rise = previous 0, current 1.
  - DE fall = previous 1, current 0.
- **x**: 0 on a DE-rise cycle, then +1 on each further DE-high cycle. It holds while DE is low.
- **y**: cleared on VSYNC fall. It increments on each DE fall.
- **Line counter (hcnt)**: counts clocks. On HSYNC fall, hcnt+1 is captured as the line length and hcnt restarts at 0.
- **Active-run counter (acnt)**: counts DE-high clocks. On DE fall it yields the line width.
  - On the first DE fall of a frame, this width is stored as the frame width.
  - On each later DE fall, the width is compared with the stored frame width. A mismatch pulses `line_err`.
- **Frame counters**: `vcnt` counts HSYNC falls and `lcnt` counts DE falls since the last VSYNC fall.
- **On VSYNC fall**, latch the following into the shadow copy:
  - `width` = frame width;
  - `height` = lcnt;
  - `htotal` = last line length;
  - `vtotal` = vcnt, which includes an HSYNC fall in the same cycle;
  - then clear vcnt and lcnt.
- **meas_valid**: the first VSYNC fall after reset only opens a frame and latches nothing. `meas_valid` is set at the second VSYNC fall.
- **Lock**: at each latch, compare the new {width, height, htotal, vtotal} with the previously latched set.
  - Equal: match counter +1, saturating at LOCK_FRAMES.
  - Unequal, or any counter saturated during that frame: match counter := 0 and `locked` := 0.
  - `locked` = (match counter == LOCK_FRAMES).
- **Saturation**: every counter stops at 2^CNT_W-1 and raises a per-frame sat flag. That flag forces a mismatch at the next latch.
- **x/y width**: `x` and `y` are 10 bits and wrap silently. Only the measurement outputs saturate.

## Timing
- **Latency**: an input sampled at edge k appears on `pix_valid`, `pix_color`, `x`, `y`, `frame_start`, `line_start` after edge k+1 (2 clocks).
- **Measurement outputs** update on the same edge that `frame_start` asserts.
- **`locked`** updates on that same edge.
- **`line_err`** asserts on the same edge as the `pix_valid` 1→0 transition of the offending line.
- **Reset values**:
  - All outputs 0.
  - Previous-value flops for the syncs preset to 1, so no spurious edge fires when the syncs are idle high.
  - Previous-value flop for DE preset to 0.
  - Match counter 0; `meas_valid` 0.
- **Reset mid-frame**: the partial frame is discarded. The lock sequence restarts: `locked` can assert no earlier than the (LOCK_FRAMES+2)th VSYNC fall after reset.
- **Simultaneous HSYNC fall and VSYNC fall**: the HSYNC fall is counted into vtotal, then vcnt is cleared. `line_start` and `frame_start` both pulse.
- **Simultaneous DE fall and VSYNC fall**: that line counts toward the closing frame's height.

## Test plan
- **Nominal lock**: generator defaults (480x480, H 32/20/32, V 8/2/8), 5 frames → `meas_valid`=1 at the 2nd `frame_start`.
  - `width`=480, `height`=480, `htotal`=565, `vtotal`=499.
  - `locked`=1 at the 4th `frame_start`.
  - `line_err` is never asserted.
- **Coordinates**: on line 0 of frame 3, the first `pix_valid` cycle has x=0, y=0. The last has x=479. Line 479 ends with x=479, y=479, and `pix_color` equals the driven color delayed by 2 clocks.
- **Geometry change**: after lock, switch to H_FP=40 → `locked`=0 at the next `frame_start` with `htotal`=573. `locked` reasserts 2 frames later.
- **Short line**: truncate the DE of line 100 to 470 cycles → single `line_err` pulse. `locked` drops at the next `frame_start` only if width mismatches.
- **Reset mid-frame**: assert `reset` for 1 cycle at row 200 → all outputs 0 on the next edge. `meas_valid` returns at the 2nd following VSYNC fall; `locked` at the 4th.
- **Sync loss**: hold HSYNC high with CNT_W=12 → hcnt saturates at 4095. The next VSYNC fall clears `locked`.
